// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch front end. It issues single-outstanding
//            requests to instruction memory, buffers returned words in a
//            2-entry prefetch FIFO and presents the head to the IF/ID
//            register. Redirects flush the buffer and drop stale returns.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            hold                 downstream stalled, head not consumed
//            redirect/_addr       taken branch/jump and its target
//            imem_req/_addr       memory request and word-aligned address
//            imem_ack/_rdata      memory response for oldest request
//            out_address/_instruction/_valid  buffer head to IF/ID
//            flush                one-cycle bubble request to IF/ID
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_address,
  output logic [31:0] out_instruction,
  output logic        out_valid,
  output logic        flush
);

  typedef enum logic [0:0] {
    ST_FETCH   = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_outstanding;
  logic        w_outstanding_nxt;
  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic        r_head;
  logic        r_flush;
  logic [31:0] r_fifo_addr [2];
  logic [31:0] r_fifo_inst [2];

  logic        w_room;
  logic        w_req;
  logic        w_push;
  logic        w_pop;
  logic        w_wr_idx;
  logic [31:0] w_redir_pc;

  // Space rule: a new request may start only while count + outstanding < depth.
  // Once raised, the request stays up (outstanding) until acknowledged.
  assign w_room     = (r_count < 2'(BUF_DEPTH));
  assign w_req      = (r_state == ST_FETCH) && (r_outstanding || w_room);
  assign w_push     = w_req && imem_ack && !redirect;
  assign w_pop      = (r_count != 2'd0) && !hold && !redirect;
  assign w_wr_idx   = r_head ^ r_count[0];
  assign w_redir_pc = redirect_addr & ~32'h3;

  // Gate with rst_n so the request is low while reset is asserted.
  assign imem_req        = w_req && rst_n;
  assign imem_addr       = r_pc;
  assign out_valid       = (r_count != 2'd0);
  assign out_address     = out_valid ? r_fifo_addr[r_head] : r_pc;
  assign out_instruction = out_valid ? r_fifo_inst[r_head] : 32'h0;
  assign flush           = r_flush;

  // Next-state logic. A redirect while the memory still owes an answer moves
  // to DISCARD so that answer is not mistaken for the new target's data.
  always_comb begin
    w_state_nxt       = r_state;
    w_outstanding_nxt = r_outstanding;
    case (r_state)
      ST_FETCH: begin
        w_outstanding_nxt = w_req && !imem_ack;
        if (redirect) begin
          w_outstanding_nxt = 1'b0;
          if (w_req && !imem_ack) begin
            w_state_nxt = ST_DISCARD;
          end
        end
      end
      ST_DISCARD: begin
        w_outstanding_nxt = 1'b0;
        if (imem_ack) begin
          w_state_nxt = ST_FETCH;
        end
      end
      default: begin
        w_state_nxt       = ST_FETCH;
        w_outstanding_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_outstanding <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_count <= 2'd0;
      r_head  <= 1'b0;
      r_flush <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_addr[i] <= 32'h0;
        r_fifo_inst[i] <= 32'h0;
      end
    end else begin
      r_flush <= redirect;
      if (redirect) begin
        r_pc    <= w_redir_pc;
        r_count <= 2'd0;
        r_head  <= 1'b0;
      end else begin
        if (w_push) begin
          r_fifo_addr[w_wr_idx] <= r_pc;
          r_fifo_inst[w_wr_idx] <= imem_rdata;
          r_pc                  <= r_pc + 32'd4;
        end
        if (w_pop) begin
          r_head <= ~r_head;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // The space rule must make a push into a full buffer impossible.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      assert (r_count != 2'(BUF_DEPTH));
    end
  end

endmodule
`default_nettype wire
